// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: FSM state encoding,
// default widths, and a width-parametrised saturating adder.
package snn_pkg;

  localparam int SNN_WIDTH        = 16;
  localparam int SNN_WEIGHT_WIDTH = 8;
  localparam int SNN_N_INPUTS     = 8;
  localparam int SNN_DECAY_SHIFT  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } syn_state_e;

  // Adds two sign-extended operands one bit wider than needed and clamps the
  // result to the signed range of `width` bits (width <= 32).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    logic signed [31:0] res;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (width - 1));
    if (sum > hi) begin
      res = 32'(hi);
    end else if (sum < lo) begin
      res = 32'(lo);
    end else begin
      res = 32'(sum);
    end
    return res;
  endfunction

endpackage

// File: rtl/synapse_weight_rf.sv
// Per-synapse signed weight storage: one synchronous write port, one
// combinational read port, cleared by the asynchronous reset.
module synapse_weight_rf #(
  parameter int N_INPUTS     = 8,
  parameter int WEIGHT_WIDTH = 8,
  localparam int IDX_W       = $clog2(N_INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_waddr,
  input  logic [WEIGHT_WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0]        i_raddr,
  output logic [WEIGHT_WIDTH-1:0] o_rdata
);
  import snn_pkg::*;

  localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_INPUTS);

  logic [WEIGHT_WIDTH-1:0] r_mem [N_INPUTS];
  logic                    w_addr_ok;

  assign w_addr_ok = ({1'b0, i_waddr} < N_LIM);

  // Out-of-range addresses only exist for non-power-of-two N and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && w_addr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/synapse_current_gen.sv
// Converts a per-timestep spike vector into a decaying, saturating synaptic
// current: decay on accept, one weighted add per cycle, then publish.
module synapse_current_gen
  import snn_pkg::*;
#(
  parameter int WIDTH        = SNN_WIDTH,
  parameter int N_INPUTS     = SNN_N_INPUTS,
  parameter int WEIGHT_WIDTH = SNN_WEIGHT_WIDTH,
  parameter int DECAY_SHIFT  = SNN_DECAY_SHIFT,
  localparam int IDX_W       = $clog2(N_INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_INPUTS-1:0]     spike_in,
  input  logic                    spike_valid,
  output logic                    spike_ready,
  input  logic                    w_we,
  input  logic [IDX_W-1:0]        w_addr,
  input  logic [WEIGHT_WIDTH-1:0] w_data,
  output logic [WIDTH-1:0]        input_current,
  output logic                    current_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  syn_state_e              r_state;
  syn_state_e              w_next_state;
  logic [N_INPUTS-1:0]     r_spikes;
  logic signed [WIDTH-1:0] r_acc;
  logic signed [WIDTH-1:0] r_current;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_valid;
  logic [WEIGHT_WIDTH-1:0] w_weight;
  logic signed [WIDTH-1:0] w_decayed;
  logic signed [WIDTH-1:0] w_sum;

  synapse_weight_rf #(
    .N_INPUTS    (N_INPUTS),
    .WEIGHT_WIDTH(WEIGHT_WIDTH)
  ) u_weight_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_we),
    .i_waddr(w_addr),
    .i_wdata(w_data),
    .i_raddr(r_idx),
    .o_rdata(w_weight)
  );

  // Shift floors toward minus infinity: small positives persist, -1 decays to 0.
  assign w_decayed = r_current - (r_current >>> DECAY_SHIFT);
  assign w_sum     = WIDTH'(sat_add(32'(r_acc), 32'(signed'(w_weight)), WIDTH));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (spike_valid) begin
          w_next_state = ACCUM;
        end else begin
          w_next_state = IDLE;
        end
      end
      ACCUM: begin
        if (r_idx == LAST_IDX) begin
          w_next_state = OUTPUT;
        end else begin
          w_next_state = ACCUM;
        end
      end
      OUTPUT:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    spike_ready = 1'b0;
    case (r_state)
      IDLE:    spike_ready = 1'b1;
      default: spike_ready = 1'b0;
    endcase
  end

  // Datapath: latch spikes, accumulate one synapse per cycle, publish result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spikes  <= '0;
      r_acc     <= '0;
      r_current <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (spike_valid) begin
            r_spikes <= spike_in;
            r_acc    <= w_decayed;
            r_idx    <= '0;
          end
        end
        ACCUM: begin
          if (r_spikes[r_idx]) begin
            r_acc <= w_sum;
          end
          r_idx <= r_idx + 1'b1;
        end
        OUTPUT: begin
          r_current <= r_acc;
          r_valid   <= 1'b1;
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign input_current = r_current;
  assign current_valid = r_valid;

endmodule

// File: tb/tb_synapse_current_gen.sv
// Scoreboard bench: two instances (16-bit and 8-bit current) share stimulus;
// a behavioural model predicts each published current.
module tb_synapse_current_gen;

  localparam int N   = 8;
  localparam int LAT = N + 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] spike_in;
  logic         spike_valid;
  logic         w_we;
  logic [2:0]   w_addr;
  logic [7:0]   w_data;
  logic         ready16, ready8;
  logic [15:0]  cur16;
  logic [7:0]   cur8;
  logic         val16, val8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int c16;
    int c8;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  int wm[N];
  int m16, m8;
  bit prev_val;

  synapse_current_gen dut (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .spike_valid(spike_valid),
    .spike_ready(ready16), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .input_current(cur16), .current_valid(val16)
  );

  synapse_current_gen #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .spike_valid(spike_valid),
    .spike_ready(ready8), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .input_current(cur8), .current_valid(val8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int clamp_add(input int a, input int b, input int w);
    int s, hi, lo;
    s  = a + b;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  // One timestep from the rules: decay (floor of cur/4 removed), then add the
  // weight of each spiking synapse in index order, clamping after every add.
  function automatic int model_step(input int cur, input logic [N-1:0] sp,
                                    input int w, input int eff[N]);
    int acc;
    acc = cur - (cur >>> 2);
    for (int i = 0; i < N; i++) begin
      if (sp[i]) acc = clamp_add(acc, eff[i], w);
    end
    return acc;
  endfunction

  task automatic write_w(input int a, input logic [7:0] d);
    @(negedge clk);
    w_we   = 1'b1;
    w_addr = 3'(a);
    w_data = d;
    @(posedge clk);
    #1;
    w_we = 1'b0;
    wm[a] = int'(signed'(d));
  endtask

  // wk: cycle offset from the accept cycle at which a write is driven.
  // noise: 0 none, 1 random, 2 spike_valid held high while busy.
  task automatic do_step(input logic [N-1:0] sp, input bit wr, input int wk,
                         input int wa, input logic [7:0] wd, input int noise,
                         input bit rst_mid);
    int eff[N];
    int waited;
    int k0;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!ready16 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ready16) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    k0          = cyc;
    spike_in    = sp;
    spike_valid = 1'b1;
    w_we        = wr && (wk == 0);
    w_addr      = 3'(wa);
    w_data      = wd;
    for (int i = 0; i < N; i++) begin
      eff[i] = wm[i];
      if (wr && wk <= i && wa == i) eff[i] = int'(signed'(wd));
    end
    e.c16 = model_step(m16, sp, 16, eff);
    e.c8  = model_step(m8, sp, 8, eff);
    e.cyc = k0 + LAT;
    if (!rst_mid) begin
      exp_q.push_back(e);
      m16 = e.c16;
      m8  = e.c8;
      if (wr) wm[wa] = int'(signed'(wd));
    end
    @(negedge clk);
    for (int k = 1; k < LAT; k++) begin
      chk("busy_ready16", int'(ready16), 0);
      chk("busy_ready8", int'(ready8), 0);
      if (rst_mid && k == 3) begin
        rst_n       = 1'b0;
        spike_valid = 1'b0;
        w_we        = 1'b0;
        for (int i = 0; i < N; i++) wm[i] = 0;
        m16 = 0;
        m8  = 0;
        repeat (2) @(negedge clk);
        chk("rst_cur16", int'($signed(cur16)), 0);
        chk("rst_cur8", int'($signed(cur8)), 0);
        chk("rst_valid", int'(val16), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", int'(ready16), 1);
        return;
      end
      spike_valid = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom) : 1'b0;
      spike_in    = N'($urandom);
      w_we        = wr && (wk == k);
      @(negedge clk);
    end
    spike_valid = 1'b0;
    w_we        = 1'b0;
    chk("idle_ready16", int'(ready16), 1);
  endtask

  // Monitor: every published current is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (val16 || val8) chk("valid_match", int'(val8), int'(val16));
      if (val16 && prev_val) chk("valid_consecutive", 1, 0);
      if (val16) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("current16", int'($signed(cur16)), e.c16);
          chk("current8", int'($signed(cur8)), e.c8);
          chk("latency_cycle", cyc, e.cyc);
        end
      end
      prev_val = val16;
    end else begin
      prev_val = 1'b0;
    end
  end

  initial begin
    int t;
    rst_n       = 1'b0;
    spike_in    = '0;
    spike_valid = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_data      = '0;
    prev_val    = 1'b0;
    m16 = 0;
    m8  = 0;
    for (int i = 0; i < N; i++) wm[i] = 0;
    repeat (3) @(negedge clk);
    chk("reset_cur16", int'($signed(cur16)), 0);
    chk("reset_valid", int'(val16), 0);
    rst_n = 1'b1;
    #1;
    chk("reset_ready16", int'(ready16), 1);
    chk("reset_ready8", int'(ready8), 1);

    // Basic accumulate, then pure decay 80 -> 60 -> 45 -> 34.
    write_w(0, 8'd100);
    write_w(3, 8'hEC);
    do_step(8'b0000_1001, 1'b0, 0, 0, 8'd0, 0, 1'b0);
    repeat (3) do_step(8'h00, 1'b0, 0, 0, 8'd0, 0, 1'b0);

    // Backpressure, then a same-cycle write to the synapse being read.
    do_step(8'b0000_1001, 1'b0, 0, 0, 8'd0, 2, 1'b0);
    do_step(8'b0000_1001, 1'b1, 4, 3, 8'd50, 0, 1'b0);
    do_step(8'b0000_1001, 1'b0, 0, 0, 8'd0, 0, 1'b0);

    // Saturation at both rails.
    for (int i = 0; i < N; i++) write_w(i, 8'd127);
    repeat (2) do_step(8'hFF, 1'b0, 0, 0, 8'd0, 0, 1'b0);
    for (int i = 0; i < N; i++) write_w(i, 8'h80);
    repeat (2) do_step(8'hFF, 1'b0, 0, 0, 8'd0, 1, 1'b0);

    // Reset in the middle of accumulation, then confirm weights were cleared.
    do_step(8'hFF, 1'b0, 0, 0, 8'd0, 0, 1'b1);
    do_step(8'hFF, 1'b0, 0, 0, 8'd0, 0, 1'b0);

    // Decay rounding: -1 decays to 0, 3 persists.
    write_w(0, 8'hFF);
    do_step(8'h01, 1'b0, 0, 0, 8'd0, 0, 1'b0);
    do_step(8'h00, 1'b0, 0, 0, 8'd0, 0, 1'b0);
    write_w(0, 8'd3);
    do_step(8'h01, 1'b0, 0, 0, 8'd0, 0, 1'b0);
    do_step(8'h00, 1'b0, 0, 0, 8'd0, 0, 1'b0);

    // Randomised traffic with writes before and during timesteps.
    repeat (40) begin
      repeat ($urandom_range(0, 2)) write_w($urandom_range(0, N - 1), 8'($urandom));
      do_step(N'($urandom), 1'($urandom), $urandom_range(0, LAT - 1),
              $urandom_range(0, N - 1), 8'($urandom), $urandom_range(0, 2), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
